// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state codes, instruction opcodes, default IDCODE.
// Latency: n/a (constants only).
// Backpressure: n/a.
package jtag_pkg;

    // TAP controller current_state codes
    localparam logic [4:0] TAP_TLR      = 5'h00;
    localparam logic [4:0] TAP_RTI      = 5'h01;
    localparam logic [4:0] TAP_SEL_DR   = 5'h02;
    localparam logic [4:0] TAP_SEL_IR   = 5'h03;
    localparam logic [4:0] TAP_CAP_DR   = 5'h04;
    localparam logic [4:0] TAP_CAP_IR   = 5'h05;
    localparam logic [4:0] TAP_SH_DR    = 5'h06;
    localparam logic [4:0] TAP_SH_IR    = 5'h07;
    localparam logic [4:0] TAP_EX1_DR   = 5'h08;
    localparam logic [4:0] TAP_EX1_IR   = 5'h09;
    localparam logic [4:0] TAP_PAUSE_DR = 5'h10;
    localparam logic [4:0] TAP_PAUSE_IR = 5'h11;
    localparam logic [4:0] TAP_EX2_DR   = 5'h12;
    localparam logic [4:0] TAP_EX2_IR   = 5'h13;
    localparam logic [4:0] TAP_UPD_DR   = 5'h14;
    localparam logic [4:0] TAP_UPD_IR   = 5'h15;

    // Instruction opcodes; anything not listed behaves as BYPASS
    localparam logic [3:0] OP_ABORT  = 4'b1000;
    localparam logic [3:0] OP_USER   = 4'b0010;
    localparam logic [3:0] OP_IDCODE = 4'b1110;
    localparam logic [3:0] OP_BYPASS = 4'b1111;

    localparam logic [31:0] IDCODE_DEFAULT = 32'h000F_AF01;

    // Data register selected by the active instruction
    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_IDCODE = 2'd1,
        SEL_USER   = 2'd2
    } dr_sel_e;

endpackage

// File: rtl/jtag_dr_ir_chain_if.sv
// TAP-side scan bus: state code and TDI in, TDO and decoded side-effects out.
// Latency: n/a (wires only).
// Backpressure: none; TAP state advances every tck.
interface jtag_dr_ir_chain_if #(
    parameter int IR_WIDTH      = 4,
    parameter int USER_DR_WIDTH = 8
) ();
    logic [4:0]               tap_state;
    logic                     tdi;
    logic                     tdo;
    logic                     tdo_en;
    logic [IR_WIDTH-1:0]      ir_value;
    logic [USER_DR_WIDTH-1:0] user_dr_out;
    logic                     user_dr_update;
    logic                     abort_pulse;

    // TAP controller / core side
    modport master (
        output tap_state, tdi,
        input  tdo, tdo_en, ir_value, user_dr_out, user_dr_update, abort_pulse
    );

    // Scan-register chain side
    modport slave (
        input  tap_state, tdi,
        output tdo, tdo_en, ir_value, user_dr_out, user_dr_update, abort_pulse
    );
endinterface

// File: rtl/jtag_shift_reg.sv
// Generic capture/shift scan register, LSB shifts out, tdi enters at MSB.
// Latency: capture/shift take effect on the tck edge they are asserted on.
// Backpressure: none; holds when neither capture nor shift is asserted.
module jtag_shift_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             tck,
    input  logic             reset,
    input  logic             capture,
    input  logic [WIDTH-1:0] capture_value,
    input  logic             shift,
    input  logic             tdi,
    output logic [WIDTH-1:0] q,
    output logic             lsb
);
    logic [WIDTH-1:0] r_q;

    // Capture has priority; shifting past WIDTH simply recirculates tdi bits
    always_ff @(posedge tck) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (capture) begin
            r_q <= capture_value;
        end else if (shift) begin
            r_q <= {tdi, r_q[WIDTH-1:1]};
        end
    end

    assign q   = r_q;
    assign lsb = r_q[0];
endmodule

// File: rtl/jtag_dr_ir_chain.sv
// Instruction register, IDCODE/BYPASS/USER data registers and TDO mux behind the TAP.
// Latency: register actions on the tck edge of the matching state; tdo/tdo_en combinational.
// Backpressure: none; follows tap_state every cycle, unknown codes are ignored.
module jtag_dr_ir_chain
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE_VALUE  = IDCODE_DEFAULT,
    parameter int          USER_DR_WIDTH = 8
) (
    input  logic               tck,
    input  logic               reset,
    jtag_dr_ir_chain_if.slave  bus
);
    localparam logic [IR_WIDTH-1:0] L_OP_USER   = IR_WIDTH'(OP_USER);
    localparam logic [IR_WIDTH-1:0] L_OP_IDCODE = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] L_OP_ABORT  = IR_WIDTH'(OP_ABORT);
    localparam logic [IR_WIDTH-1:0] L_IR_CAP    = IR_WIDTH'(1);

    logic [IR_WIDTH-1:0]      r_ir_value;
    logic [USER_DR_WIDTH-1:0] r_user_dr_out;
    logic                     r_bypass;
    logic                     r_user_upd;
    logic                     r_abort;

    logic                     w_cap_dr, w_cap_ir, w_sh_dr, w_sh_ir;
    dr_sel_e                  w_sel;
    logic [IR_WIDTH-1:0]      w_ir_q;
    logic                     w_ir_lsb;
    logic [31:0]              w_unused_idcode_q;
    logic                     w_idcode_lsb;
    logic [USER_DR_WIDTH-1:0] w_user_q;
    logic                     w_user_lsb;
    logic                     w_tdo;

    assign w_cap_dr = (bus.tap_state == TAP_CAP_DR);
    assign w_cap_ir = (bus.tap_state == TAP_CAP_IR);
    assign w_sh_dr  = (bus.tap_state == TAP_SH_DR);
    assign w_sh_ir  = (bus.tap_state == TAP_SH_IR);

    // Active instruction decodes to one data register; unlisted opcodes and ABORT use bypass
    always_comb begin
        w_sel = SEL_BYPASS;
        if (r_ir_value == L_OP_USER) begin
            w_sel = SEL_USER;
        end else if (r_ir_value == L_OP_IDCODE) begin
            w_sel = SEL_IDCODE;
        end
    end

    jtag_shift_reg #(.WIDTH(IR_WIDTH), .RESET_VALUE(L_IR_CAP)) u_ir_shift (
        .tck(tck), .reset(reset),
        .capture(w_cap_ir), .capture_value(L_IR_CAP),
        .shift(w_sh_ir), .tdi(bus.tdi),
        .q(w_ir_q), .lsb(w_ir_lsb)
    );

    jtag_shift_reg #(.WIDTH(32), .RESET_VALUE('0)) u_idcode_shift (
        .tck(tck), .reset(reset),
        .capture(w_cap_dr && (w_sel == SEL_IDCODE)), .capture_value(IDCODE_VALUE),
        .shift(w_sh_dr && (w_sel == SEL_IDCODE)), .tdi(bus.tdi),
        .q(w_unused_idcode_q), .lsb(w_idcode_lsb)
    );

    // USER captures its own output register so a scan reads back the last write
    jtag_shift_reg #(.WIDTH(USER_DR_WIDTH), .RESET_VALUE('0)) u_user_shift (
        .tck(tck), .reset(reset),
        .capture(w_cap_dr && (w_sel == SEL_USER)), .capture_value(r_user_dr_out),
        .shift(w_sh_dr && (w_sel == SEL_USER)), .tdi(bus.tdi),
        .q(w_user_q), .lsb(w_user_lsb)
    );

    // One-bit bypass register: cleared on capture, loads tdi on shift
    always_ff @(posedge tck) begin
        if (reset) begin
            r_bypass <= 1'b0;
        end else if (w_cap_dr && (w_sel == SEL_BYPASS)) begin
            r_bypass <= 1'b0;
        end else if (w_sh_dr && (w_sel == SEL_BYPASS)) begin
            r_bypass <= bus.tdi;
        end
    end

    // Instruction/user output registers and one-cycle side-effect pulses
    always_ff @(posedge tck) begin
        if (reset) begin
            r_ir_value    <= L_OP_IDCODE;
            r_user_dr_out <= '0;
            r_user_upd    <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_user_upd <= 1'b0;
            r_abort    <= 1'b0;
            case (bus.tap_state)
                TAP_TLR: begin
                    r_ir_value    <= L_OP_IDCODE;
                    r_user_dr_out <= '0;
                end
                TAP_UPD_IR: begin
                    r_ir_value <= w_ir_q;
                end
                TAP_UPD_DR: begin
                    if (w_sel == SEL_USER) begin
                        r_user_dr_out <= w_user_q;
                        r_user_upd    <= 1'b1;
                    end else if (r_ir_value == L_OP_ABORT) begin
                        r_abort <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // TDO follows the register being shifted; quiet outside shift states and in reset
    always_comb begin
        w_tdo = 1'b0;
        if (!reset) begin
            if (w_sh_ir) begin
                w_tdo = w_ir_lsb;
            end else if (w_sh_dr) begin
                case (w_sel)
                    SEL_USER:   w_tdo = w_user_lsb;
                    SEL_IDCODE: w_tdo = w_idcode_lsb;
                    default:    w_tdo = r_bypass;
                endcase
            end
        end
    end

    assign bus.tdo            = w_tdo;
    assign bus.tdo_en         = (w_sh_dr || w_sh_ir) && !reset;
    assign bus.ir_value       = r_ir_value;
    assign bus.user_dr_out    = r_user_dr_out;
    assign bus.user_dr_update = r_user_upd && !reset;
    assign bus.abort_pulse    = r_abort && !reset;
endmodule

// File: tb/tb_jtag_dr_ir_chain.sv
// Scoreboarded bench for jtag_dr_ir_chain: directed scans then random IR/DR scans.
// Latency: expected tdo/pulse values queued by the driver, popped by the monitor.
// Backpressure: none; monitor samples on the falling tck edge.
module tb_jtag_dr_ir_chain;
    import jtag_pkg::*;

    logic tck   = 1'b0;
    logic reset = 1'b1;

    jtag_dr_ir_chain_if #(.IR_WIDTH(4), .USER_DR_WIDTH(8)) bus ();

    jtag_dr_ir_chain #(
        .IR_WIDTH(4), .IDCODE_VALUE(32'h000F_AF01), .USER_DR_WIDTH(8)
    ) dut (
        .tck(tck), .reset(reset), .bus(bus)
    );

    always #5 tck = ~tck;

    localparam logic [31:0] EXP_IDCODE = 32'h000F_AF01;

    int         n_pass  = 0;
    int         n_total = 0;
    bit         q_tdo[$];
    logic [7:0] q_user[$];
    logic [7:0] q_abort[$];

    // Reference model: active instruction and last written USER value
    logic [3:0] m_ir;
    logic [7:0] m_user;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endfunction

    task automatic drive(input logic [4:0] st, input logic b);
        bus.tap_state = st;
        bus.tdi       = b;
        @(posedge tck);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic reset_dut();
        reset = 1'b1;
        drive(TAP_TLR, 1'b0);
        drive(TAP_TLR, 1'b0);
        reset = 1'b0;
        m_ir   = OP_IDCODE;
        m_user = 8'h00;
    endtask

    // IR scan: scanned-out stream is the captured 0001 followed by the shifted-in opcode
    task automatic ir_scan(input logic [3:0] op);
        bit s[$];
        s = {1'b1, 1'b0, 1'b0, 1'b0, op[0], op[1], op[2], op[3]};
        drive(TAP_SEL_DR, rb());
        drive(TAP_SEL_IR, rb());
        drive(TAP_CAP_IR, rb());
        for (int k = 0; k < 4; k++) begin
            q_tdo.push_back(s[k]);
            drive(TAP_SH_IR, op[k]);
        end
        drive(TAP_EX1_IR, rb());
        drive(TAP_UPD_IR, rb());
        m_ir = op;
        drive(TAP_RTI, rb());
        chk("ir_value", 64'(bus.ir_value), 64'(m_ir));
    endtask

    // Build the scanned-out stream (captured bits then tdi bits) of the selected register
    task automatic dr_open(output bit s[$], output int w, input int n, input logic [63:0] bits);
        logic [31:0] cap;
        s = {};
        if (m_ir == OP_USER)        begin w = 8;  cap = {24'h0, m_user}; end
        else if (m_ir == OP_IDCODE) begin w = 32; cap = EXP_IDCODE;      end
        else                        begin w = 1;  cap = 32'h0;           end
        for (int i = 0; i < w; i++) s.push_back(cap[i]);
        for (int k = 0; k < n; k++) s.push_back(bits[k]);
        drive(TAP_SEL_DR, rb());
        drive(TAP_CAP_DR, rb());
    endtask

    task automatic dr_scan(input int n, input logic [63:0] bits, input int pause_at, input int pause_len);
        bit         s[$];
        int         w;
        logic [7:0] nv;
        dr_open(s, w, n, bits);
        for (int k = 0; k < n; k++) begin
            if (k == pause_at) begin
                drive(TAP_EX1_DR, rb());
                repeat (pause_len) drive(TAP_PAUSE_DR, rb());
                drive(TAP_EX2_DR, rb());
            end
            q_tdo.push_back(s[k]);
            drive(TAP_SH_DR, bits[k]);
        end
        drive(TAP_EX1_DR, rb());
        if (m_ir == OP_USER) begin
            for (int j = 0; j < 8; j++) nv[j] = s[n + j];
            m_user = nv;
            q_user.push_back(nv);
        end else if (m_ir == OP_ABORT) begin
            q_abort.push_back(m_user);
        end
        drive(TAP_UPD_DR, rb());
        drive(TAP_RTI, rb());
        chk("user_dr_out", 64'(bus.user_dr_out), 64'(m_user));
    endtask

    initial begin
        bus.tap_state = TAP_TLR;
        bus.tdi       = 1'b0;
        fork
            // Monitor: every DUT-presented output pops its expected value
            begin : monitor
                forever begin
                    @(negedge tck);
                    if (bus.tdo_en) begin
                        if (q_tdo.size() == 0) begin
                            n_total++;
                            $display("FAIL tdo_en: got 1 want 0 (state %0h)", bus.tap_state);
                        end else begin
                            bit e;
                            e = q_tdo.pop_front();
                            chk("tdo", 64'(bus.tdo), 64'(e));
                        end
                    end
                    if (bus.user_dr_update) begin
                        if (q_user.size() == 0) begin
                            n_total++;
                            $display("FAIL user_dr_update: got 1 want 0");
                        end else begin
                            logic [7:0] e;
                            e = q_user.pop_front();
                            chk("user_pulse_val", 64'(bus.user_dr_out), 64'(e));
                        end
                    end
                    if (bus.abort_pulse) begin
                        if (q_abort.size() == 0) begin
                            n_total++;
                            $display("FAIL abort_pulse: got 1 want 0");
                        end else begin
                            logic [7:0] e;
                            e = q_abort.pop_front();
                            chk("abort_user_keep", 64'(bus.user_dr_out), 64'(e));
                        end
                    end
                end
            end
            begin : watchdog
                #500000;
                $display("FAIL watchdog: got timeout want completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        reset_dut();
        drive(TAP_TLR, 1'b0);
        chk("rst_ir", 64'(bus.ir_value), 64'h0E);
        chk("rst_user", 64'(bus.user_dr_out), 64'h00);
        chk("rst_upd", 64'(bus.user_dr_update), 64'h0);
        chk("rst_abort", 64'(bus.abort_pulse), 64'h0);
        chk("rst_tdo", 64'(bus.tdo), 64'h0);
        chk("rst_tdo_en", 64'(bus.tdo_en), 64'h0);
        drive(TAP_RTI, 1'b0);

        // IDCODE readout, then all-ones IR and bypass
        dr_scan(32, 64'h0, -1, 0);
        ir_scan(OP_BYPASS);
        dr_scan(4, 64'b1101, -1, 0);

        // USER write and readback, ABORT, unlisted opcode
        ir_scan(OP_USER);
        dr_scan(8, 64'hA5, -1, 0);
        dr_scan(8, 64'h00, -1, 0);
        ir_scan(OP_ABORT);
        dr_scan(3, 64'b101, -1, 0);
        ir_scan(4'b0101);
        dr_scan(5, 64'b10111, -1, 0);

        // Paused USER scan matches a continuous one
        ir_scan(OP_USER);
        dr_scan(8, 64'h3C, 3, 4);

        // Reset mid-shift
        begin
            bit s[$];
            int w;
            dr_open(s, w, 5, 64'b10110);
            for (int k = 0; k < 5; k++) begin
                q_tdo.push_back(s[k]);
                drive(TAP_SH_DR, s[w + k]);
            end
            reset = 1'b1;
            drive(TAP_SH_DR, 1'b1);
            chk("midrst_ir", 64'(bus.ir_value), 64'h0E);
            chk("midrst_user", 64'(bus.user_dr_out), 64'h00);
            drive(TAP_UPD_DR, 1'b0);
            reset = 1'b0;
            m_ir   = OP_IDCODE;
            m_user = 8'h00;
            repeat (3) drive(5'h0A, rb());
            chk("badstate_ir", 64'(bus.ir_value), 64'h0E);
            chk("badstate_user", 64'(bus.user_dr_out), 64'h00);
            drive(TAP_RTI, 1'b0);
        end

        // Random IR/DR scans against the model
        for (int it = 0; it < 30; it++) begin
            logic [3:0]  op;
            logic [63:0] bits;
            int          n, pa;
            case ($urandom_range(0, 4))
                0:       op = OP_USER;
                1:       op = OP_IDCODE;
                2:       op = OP_BYPASS;
                3:       op = OP_ABORT;
                default: op = 4'($urandom);
            endcase
            ir_scan(op);
            bits = {32'($urandom), 32'($urandom)};
            n    = $urandom_range(1, 40);
            pa   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            dr_scan(n, bits, pa, $urandom_range(1, 4));
        end

        // TLR clears instruction and USER output
        ir_scan(OP_USER);
        dr_scan(8, 64'h5A, -1, 0);
        drive(TAP_TLR, 1'b0);
        m_ir   = OP_IDCODE;
        m_user = 8'h00;
        chk("tlr_ir", 64'(bus.ir_value), 64'(m_ir));
        chk("tlr_user", 64'(bus.user_dr_out), 64'(m_user));
        drive(TAP_RTI, 1'b0);
        dr_scan(32, 64'h0, -1, 0);

        drive(TAP_RTI, 1'b0);
        drive(TAP_RTI, 1'b0);
        chk("tdo_left", 64'(q_tdo.size()), 64'h0);
        chk("user_left", 64'(q_user.size()), 64'h0);
        chk("abort_left", 64'(q_abort.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/jtag_dr_ir_chain.md
Name: jtag_dr_ir_chain

Overview:
Scan-register stage directly downstream of the JTAG TAP controller. It consumes the TAP's registered state code plus TDI, and implements:
- the 4-bit instruction register
- the IDCODE, BYPASS and USER data registers
- TDO selection
It replaces the ad-hoc byte_transmitter/mux path and exports decoded instruction side-effects (user register write, abort pulse) to the core.

Parameters:
IR_WIDTH, 4, instruction register width
IDCODE_VALUE, 32'h000FAF01, value captured in Capture-DR under IDCODE
USER_DR_WIDTH, 8, width of USER data register

Ports:
tck  input  1  JTAG clock; all state updates on rising edge
reset  input  1  synchronous active-high reset (TAP drives this from trst)
tap_state  input  5  TAP current_state code (encoding in jtag_pkg)
tdi  input  1  serial data in
tdo  output  1  serial data out
tdo_en  output  1  high while tap_state is ShiftDr or ShiftIr
ir_value  output  IR_WIDTH  active instruction
user_dr_out  output  USER_DR_WIDTH  last value written via USER instruction
user_dr_update  output  1  one-tck pulse when user_dr_out is written
abort_pulse  output  1  one-tck pulse on Update-DR under ABORT

Behaviour:
- Reset values: ir_value=IDCODE (4'b1110); IR shift=4'b0001; IDCODE/bypass/user shift regs=0; user_dr_out=0; user_dr_update=0; abort_pulse=0; tdo=0; tdo_en=0.
- tap_state semantics: the action for state S occurs on the rising tck edge where tap_state==S. tdo and tdo_en are combinational from the current tap_state and the shift registers; no output latency beyond that.
- State codes: TLR 0, RTI 1, SelDR 2, SelIR 3, CapDR 4, CapIR 5, ShDR 6, ShIR 7, Ex1DR 8, Ex1IR 9, PauseDR 10h, PauseIR 11h, Ex2DR 12h, Ex2IR 13h, UpdDR 14h, UpdIR 15h. Any other code: no action, tdo_en=0, tdo=0.
- Opcodes:
  - ABORT=1000 selects bypass.
  - USER=0010 selects the USER register.
  - IDCODE=1110 selects IDCODE.
  - BYPASS=1111 and every unlisted opcode select bypass.
- TLR: ir_value<=IDCODE, user_dr_out<=0; shift registers unchanged.
- CapIR: ir_shift<=4'b0001.
- ShIR: ir_shift<={tdi, ir_shift[IR_WIDTH-1:1]}; tdo=ir_shift[0].
- UpdIR: ir_value<=ir_shift.
- CapDR, selected register only:
  - IDCODE reg<=IDCODE_VALUE.
  - bypass<=0.
  - user shift<=user_dr_out (readback).
- ShDR: selected register shifts LSB-first, tdi into MSB; tdo=selected[0]. Bypass is 1 bit, so output equals tdi delayed one shift.
- UpdDR:
  - Under USER: user_dr_out<=user shift, user_dr_update=1 for exactly the next cycle.
  - Under ABORT: abort_pulse=1 for the next cycle.
  - Under other instructions: no effect.
- Pause/Exit states: all registers hold; shifting resumes from the held position on return to Shift.
- ir_value changes only in UpdIR, TLR or reset. An IR change never alters DR contents until the next Capture.
- Reset has priority over every tap_state action, including mid-shift. Pending pulses are suppressed in the same cycle.
- Shift count is unbounded: shifting past register width recirculates tdi bits, with no wrap error.

Decomposition:
- Shared package jtag_pkg holds:
  - 5-bit TAP state localparams (the codes above)
  - opcode constants ABORT/IDCODE/BYPASS/USER
  - default IDCODE value
- The TAP controller and this block both import jtag_pkg.
- One sub-module, jtag_shift_reg, parameter WIDTH, with:
  - inputs: capture, capture_value, shift, tdi
  - outputs: q, lsb
- jtag_shift_reg is instantiated for IR, IDCODE and USER. Bypass is a single flop inline.

Test Plan:
1. Reset, then TLR→RTI→SelDR→CapDR, 32 ShDR cycles with tdi=0 → tdo LSB-first reconstructs 0x000FAF01; tdo_en high for exactly 32 cycles.
2. IR scan shifting 1,1,1,1 → tdo 1,0,0,0; after UpdIR ir_value=4'hF. DR scan with tdi 1,0,1,1 → tdo 0,1,0,1.
3. IR=0010, DR scan shifting 0xA5 LSB-first → after UpdDR user_dr_out=0xA5 and user_dr_update high exactly one cycle. Next DR scan with tdi=0 reads back 0xA5 on tdo.
4. IR=1000, pass through UpdDR → abort_pulse high one cycle; user_dr_out unchanged. IR=0101 then DR scan → behaves as bypass (first tdo=0).
5. IR=USER: shift 3 bits, PauseDR 4 cycles, Ex2DR, shift 5 bits (total 0x3C) → user_dr_out=0x3C, identical to a continuous scan.
6. reset asserted after 5 USER shift bits → same cycle: ir_value=4'hE, user_dr_out=0, tdo_en=0, no user_dr_update. Driving tap_state=5'h0A → tdo_en=0, no register change.
